// File: rtl/deserializer_8bit_if.sv
// Serial-in / parallel-out stream bundle for deserializer_8bit.
// The slave side is the deserializer; the master side drives bits and consumes words.
interface deserializer_8bit_if;
   logic       in_bit;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_word;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] bit_idx;

   modport slave (
      input  in_bit,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_word,
      output out_valid,
      output bit_idx
   );

   modport master (
      output in_bit,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_word,
      input  out_valid,
      input  bit_idx
   );
endinterface

// File: rtl/deserializer_8bit.sv
// Collects 8 serial bits into a registered word with valid/ready on both sides.
// Bits 0..6 of the next word may arrive while the previous word is still held.
module deserializer_8bit #(
   parameter bit MSB_FIRST = 1'b0
) (
   input logic                  clk,
   input logic                  rst_n,
   input logic                  clear,
   deserializer_8bit_if.slave   bus
);

   logic [2:0] cnt_q, cnt_d;
   logic [7:0] asm_q, asm_d;
   logic [7:0] word_q, word_d;
   logic       valid_q, valid_d;

   logic [2:0] idx;
   logic [7:0] merged;
   logic       stall;
   logic       accept;

   assign idx = MSB_FIRST ? (3'd7 - cnt_q) : cnt_q;

   // Only the completing bit can stall, and only while the held word is unconsumed.
   assign stall  = (cnt_q == 3'd7) && valid_q && !bus.out_ready;
   assign accept = bus.in_valid && !stall && !clear;

   assign bus.in_ready  = clear || !stall;
   assign bus.out_word  = word_q;
   assign bus.out_valid = valid_q;
   assign bus.bit_idx   = idx;

   always_comb begin
      merged      = asm_q;
      merged[idx] = bus.in_bit;
   end

   always_comb begin
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      word_d  = word_q;
      valid_d = valid_q;
      if (clear) begin
         cnt_d   = 3'd0;
         asm_d   = 8'h00;
         word_d  = 8'h00;
         valid_d = 1'b0;
      end else begin
         if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
         end
         if (accept) begin
            if (cnt_q == 3'd7) begin
               word_d  = merged;
               valid_d = 1'b1;
               asm_d   = 8'h00;
               cnt_d   = 3'd0;
            end else begin
               asm_d = merged;
               cnt_d = cnt_q + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 3'd0;
         asm_q   <= 8'h00;
         word_q  <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_deserializer_8bit.sv
// Randomized and directed bench for deserializer_8bit, both bit orders side by side.
// A queue-of-bits model predicts every registered output and in_ready.
module tb_deserializer_8bit;

   logic clk;
   logic rst_n;
   logic clear;
   logic in_bit;
   logic in_valid;
   logic out_ready;

   int vectors;
   int miscompares;

   deserializer_8bit_if i0 ();
   deserializer_8bit_if i1 ();

   assign i0.in_bit    = in_bit;
   assign i0.in_valid  = in_valid;
   assign i0.out_ready = out_ready;
   assign i1.in_bit    = in_bit;
   assign i1.in_valid  = in_valid;
   assign i1.out_ready = out_ready;

   deserializer_8bit #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (i0)
   );

   deserializer_8bit #(.MSB_FIRST(1'b1)) dut_msb (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (i1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rev(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: accepted bits of the current word in arrival order, plus the
   // held word in first-bit-at-bit-0 form and its valid flag.
   bit         q[$];
   logic [7:0] held;
   bit         hv;

   function automatic bit model_stall();
      return (q.size() == 7) && hv && !out_ready;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || clear) begin
         q.delete();
         held = 8'h00;
         hv   = 1'b0;
      end else begin
         bit st;
         st = model_stall();
         if (hv && out_ready) hv = 1'b0;
         if (in_valid && !st) begin
            q.push_back(in_bit);
            if (q.size() == 8) begin
               for (int i = 0; i < 8; i++) held[i] = q[i];
               q.delete();
               hv = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         logic [2:0] n;
         n = 3'(q.size());
         chk("valid_lsb", {7'd0, i0.out_valid}, {7'd0, hv});
         chk("valid_msb", {7'd0, i1.out_valid}, {7'd0, hv});
         chk("word_lsb", i0.out_word, held);
         chk("word_msb", i1.out_word, rev(held));
         chk("idx_lsb", {5'd0, i0.bit_idx}, {5'd0, n});
         chk("idx_msb", {5'd0, i1.bit_idx}, {5'd0, 3'd7 - n});
         chk("rdy_lsb", {7'd0, i0.in_ready}, {7'd0, clear || !model_stall()});
         chk("rdy_msb", {7'd0, i1.in_ready}, {7'd0, clear || !model_stall()});
      end
   end

   task automatic drv(input bit v, input bit b, input bit r, input bit c);
      in_valid  = v;
      in_bit    = b;
      out_ready = r;
      clear     = c;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] w;
      logic [7:0] a5;
      int         hits[$];

      vectors     = 0;
      miscompares = 0;
      a5          = 8'hA5;
      rst_n       = 1'b0;
      drv(0, 0, 1, 0);
      #12;
      chk("rst_word", i0.out_word, 8'h00);
      chk("rst_valid", {7'd0, i0.out_valid}, 8'h00);
      chk("rst_idx_lsb", {5'd0, i0.bit_idx}, 8'd0);
      chk("rst_idx_msb", {5'd0, i1.bit_idx}, 8'd7);
      chk("rst_rdy", {7'd0, i0.in_ready}, 8'd1);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // A5 on both orders; msb-first bit_idx must walk 7..0
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("a5_idx_msb", {5'd0, i1.bit_idx}, 8'(7 - i));
         #1 drv(1, a5[i], 1, 0);
      end
      @(negedge clk);
      chk("a5_lsb", i0.out_word, 8'hA5);
      chk("a5_msb", i1.out_word, 8'hA5);
      chk("a5_valid", {7'd0, i0.out_valid}, 8'd1);
      #1 drv(0, 0, 1, 0);
      @(negedge clk);
      chk("a5_drop", {7'd0, i0.out_valid}, 8'd0);

      // Held 3C, 7 bits of 5A accepted, 8th stalls until out_ready
      w = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1 drv(1, w[i], 0, 0);
      end
      w = 8'h5A;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("pre_rdy", {7'd0, i0.in_ready}, 8'd1);
         #1 drv(1, w[i], 0, 0);
      end
      @(negedge clk);
      #1 drv(1, w[7], 0, 0);
      repeat (2) begin
         @(negedge clk);
         chk("stall_rdy", {7'd0, i0.in_ready}, 8'd0);
         chk("stall_word", i0.out_word, 8'h3C);
      end
      #1 drv(1, w[7], 1, 0);
      @(negedge clk);
      chk("b2b_word", i0.out_word, 8'h5A);
      chk("b2b_valid", {7'd0, i0.out_valid}, 8'd1);
      #1 drv(0, 0, 1, 0);
      @(negedge clk);

      // Continuous 24-bit stream: three pulses 8 cycles apart
      for (int i = 0; i <= 24; i++) begin
         @(negedge clk);
         if (i0.out_valid) hits.push_back(i);
         #1 drv(i < 24, 1'($urandom), 1, 0);
      end
      chk("stream_cnt", 8'(hits.size()), 8'd3);
      if (hits.size() == 3) begin
         chk("stream_gap1", 8'(hits[1] - hits[0]), 8'd8);
         chk("stream_gap2", 8'(hits[2] - hits[1]), 8'd8);
      end

      // 5 stray bits, clear, then FF
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1 drv(1, 1'(i & 1), 0, 0);
      end
      @(negedge clk);
      #1 drv(1, 0, 0, 1);
      @(negedge clk);
      chk("clr_word", i0.out_word, 8'h00);
      for (int i = 0; i < 8; i++) begin
         #1 drv(1, 1, 0, 0);
         @(negedge clk);
      end
      chk("ff_lsb", i0.out_word, 8'hFF);
      chk("ff_msb", i1.out_word, 8'hFF);
      #1 drv(1, 0, 0, 0);
      repeat (3) @(negedge clk);

      // Async reset mid-word while a word is held
      #3 rst_n = 1'b0;
      #1;
      chk("arst_word", i0.out_word, 8'h00);
      chk("arst_valid", {7'd0, i0.out_valid}, 8'd0);
      chk("arst_idx_msb", {5'd0, i1.bit_idx}, 8'd7);
      @(negedge clk);
      #1 rst_n = 1'b1;
      w = 8'h96;
      for (int i = 0; i < 8; i++) begin
         drv(1, w[i], 0, 0);
         @(negedge clk);
         #1;
      end
      chk("post_rst_lsb", i0.out_word, 8'h96);
      chk("post_rst_msb", i1.out_word, 8'h69);
      drv(0, 0, 1, 0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         #1 drv($urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      end
      @(negedge clk);
      #1 drv(0, 0, 1, 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
